// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Walks the register file debug port from FIRST_REG to LAST_REG after a
//   START pulse. Each register is sent as a 5-byte frame on an 8-bit
//   valid/ready stream: header {3'b101, index}, then data bytes MSB first.
//   The data word is snapshotted once per frame, so later register writes
//   cannot corrupt a frame that is already being sent.
//
//   Optional build macro REG_DUMP_CHECKSUM_EN: after the last frame, one
//   trailer byte is sent. It holds the XOR of every byte sent in the dump.
//
// Ports
//   CLK         system clock (posedge)
//   RESET       synchronous reset, active-low
//   START       one-cycle dump request, honoured only when idle
//   DEBUG_ADDR  register index driven to the debug read port
//   DEBUG_DATA  combinational read data for DEBUG_ADDR
//   TX_DATA     byte out
//   TX_VALID    TX_DATA valid
//   TX_READY    sink accepts byte when TX_VALID && TX_READY at posedge
//   BUSY        dump in progress (including the DONE cycle)
//   DONE        one-cycle pulse at dump completion
module reg_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  output logic [4:0]  DEBUG_ADDR,
  input  logic [31:0] DEBUG_DATA,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        BUSY,
  output logic        DONE
);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SETADDR, S_CAPTURE, S_SEND, S_DONE, S_CHKSUM
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SETADDR, S_CAPTURE, S_SEND, S_DONE
  } state_e;
`endif

  localparam logic [4:0] FIRST_A = FIRST_REG[4:0];
  localparam logic [4:0] LAST_A  = LAST_REG[4:0];

  state_e      state_q;
  logic [4:0]  addr_q;
  logic [31:0] snap_q;
  logic [2:0]  idx_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        busy_q;
  logic        done_q;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0]  xor_q;
`endif

  logic        hs;
  logic [7:0]  next_byte;

  assign hs = tx_valid_q && TX_READY;

  // Byte that follows the one at idx_q within the current frame.
  always_comb begin
    next_byte = snap_q[7:0];
    case (idx_q)
      3'd0:    next_byte = snap_q[31:24];
      3'd1:    next_byte = snap_q[23:16];
      3'd2:    next_byte = snap_q[15:8];
      default: next_byte = snap_q[7:0];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      snap_q     <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            addr_q  <= FIRST_A;
            busy_q  <= 1'b1;
            state_q <= S_SETADDR;
`ifdef REG_DUMP_CHECKSUM_EN
            xor_q   <= '0;
`endif
          end
        end
        S_SETADDR: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          snap_q     <= DEBUG_DATA;
          idx_q      <= '0;
          tx_data_q  <= {3'b101, addr_q};
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (hs) begin
`ifdef REG_DUMP_CHECKSUM_EN
            xor_q <= xor_q ^ tx_data_q;
`endif
            if (idx_q != 3'd4) begin
              idx_q     <= idx_q + 3'd1;
              tx_data_q <= next_byte;
            end else if (addr_q < LAST_A) begin
              tx_valid_q <= 1'b0;
              addr_q     <= addr_q + 5'd1;
              state_q    <= S_SETADDR;
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              // Fold the final data byte in here so the trailer is ready
              // without an extra cycle; valid stays high into the trailer.
              tx_data_q  <= xor_q ^ tx_data_q;
              state_q    <= S_CHKSUM;
`else
              tx_valid_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
`endif
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        S_CHKSUM: begin
          if (hs) begin
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign DEBUG_ADDR = addr_q;
  assign TX_DATA    = tx_data_q;
  assign TX_VALID   = tx_valid_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a full-range instance (0..31) and a
// single-register instance (30..30), both reading a shared register model.
module tb_reg_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, START, TX_READY;
  logic [4:0]  DEBUG_ADDR;
  logic [31:0] DEBUG_DATA;
  logic [7:0]  TX_DATA;
  logic        TX_VALID, BUSY, DONE;

  logic        start2;
  logic [4:0]  addr2;
  logic [31:0] data2;
  logic [7:0]  txd2;
  logic        v2, busy2, done2;

  logic [31:0] regs [32];

  always #5 CLK = ~CLK;

  assign DEBUG_DATA = regs[DEBUG_ADDR];
  assign data2      = regs[addr2];

  reg_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .DEBUG_ADDR(DEBUG_ADDR), .DEBUG_DATA(DEBUG_DATA),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .BUSY(BUSY), .DONE(DONE)
  );

  reg_dump_reader #(.FIRST_REG(30), .LAST_REG(30)) u_one (
    .CLK(CLK), .RESET(RESET), .START(start2),
    .DEBUG_ADDR(addr2), .DEBUG_DATA(data2),
    .TX_DATA(txd2), .TX_VALID(v2), .TX_READY(1'b1),
    .BUSY(busy2), .DONE(done2)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] got_q[$];
  logic [7:0] got2_q[$];
  logic [7:0] exp_q[$];

  int   cyc = 0;
  int   done_cnt, done2_cnt;
  int   rdy_mode = 0;
  int   hold_cnt;
  int   first_v;
  bit   start_req = 0, start2_req = 0, restart_sent;
  logic prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference byte stream for regs[first..last] as they stand now.
  task automatic build_exp(input int first, input int last);
    logic [7:0] x;
    logic [7:0] b;
    logic [31:0] w;
    exp_q.delete();
    x = '0;
    for (int k = first; k <= last; k++) begin
      w = regs[k];
      for (int j = 0; j < 5; j++) begin
        if (j == 0) b = {3'b101, 5'(k)};
        else        b = w[31 - 8*(j-1) -: 8];
        exp_q.push_back(b);
        x ^= b;
      end
    end
    if (CHK == 1) exp_q.push_back(x);
  endtask

  // One cycle: inputs change and outputs are sampled at negedge+1, so a
  // byte recorded here is the one handshaken at the following posedge.
  task automatic tick();
    logic rdy;
    @(negedge CLK);
    #1;
    START  = start_req;  start_req  = 0;
    start2 = start2_req; start2_req = 0;
    if (prev_hold) begin
      check("hold_valid", TX_VALID, 1'b1);
      check("hold_data", TX_DATA, prev_data);
    end
    rdy = 1'b1;
    case (rdy_mode)
      1: rdy = 1'($urandom_range(0, 1));
      2: if (got_q.size() == 17 && hold_cnt < 10) begin
           rdy = 1'b0;
           hold_cnt++;
           check("bp_valid", TX_VALID, 1'b1);
           check("bp_data", TX_DATA, 8'h00);
         end
      3: if (got_q.size() == 40 && !restart_sent) begin
           START = 1'b1;
           restart_sent = 1;
         end
      default: rdy = 1'b1;
    endcase
    TX_READY = rdy;
    if (TX_VALID && first_v < 0) first_v = cyc;
    if (TX_VALID && rdy) got_q.push_back(TX_DATA);
    if (DONE) begin
      done_cnt++;
      check("done_busy", BUSY, 1'b1);
    end
    if (v2) got2_q.push_back(txd2);
    if (done2) done2_cnt++;
    prev_hold = TX_VALID && !rdy && RESET;
    prev_data = TX_DATA;
    cyc++;
  endtask

  task automatic run_dump(input int mode, output int ncyc);
    int t0;
    got_q.delete();
    done_cnt = 0; hold_cnt = 0; restart_sent = 0; first_v = -1;
    rdy_mode = mode;
    t0 = cyc;
    start_req = 1;
    tick();
    while (done_cnt == 0 && cyc - t0 < 6000) tick();
    ncyc = cyc - t0 - 1;
    first_v = first_v - t0;
    tick();
    check("busy_after_done", BUSY, 1'b0);
    check("addr_after_done", DEBUG_ADDR, 5'd31);
    repeat (6) tick();
    check("done_count", done_cnt, 1);
  endtask

  task automatic compare_stream(input string tag);
    int mism;
    mism = 0;
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({tag, "_mismatches"}, mism, 0);
  endtask

  initial begin
    int n;
    RESET = 1'b0; START = 1'b0; TX_READY = 1'b1; start2 = 1'b0;
    for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + k;

    // 1: reset held low with START high
    start_req = 1; tick();
    start_req = 1; tick();
    check("rst_valid", TX_VALID, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_addr", DEBUG_ADDR, 5'd0);
    check("rst_data", TX_DATA, 8'h00);
    tick();
    RESET = 1'b1;
    tick(); tick();
    check("idle_no_start", BUSY, 1'b0);

    // 2: full dump, sink always ready
    build_exp(0, 31);
    run_dump(0, n);
    compare_stream("full");
    check("latency", first_v, 3);
    check("dump_cycles", n, 225 + CHK);
    if (got_q.size() >= 160) begin
      check("byte0", got_q[0], 8'hA0);
      check("byte1", got_q[1], 8'h10);
      check("byte5", got_q[5], 8'hA1);
      check("byte9", got_q[9], 8'h01);
      check("byte155", got_q[155], 8'hBF);
      check("byte159", got_q[159], 8'h1F);
    end

    // 3: ten-cycle stall on reg 3 byte b2, then random backpressure
    run_dump(2, n);
    compare_stream("bp");
    check("bp_hold_cycles", hold_cnt, 10);
    run_dump(1, n);
    compare_stream("rand");

    // 4: second START mid-dump is ignored
    run_dump(3, n);
    compare_stream("restart");
    check("restart_sent", restart_sent, 1);
    check("restart_cycles", n, 225 + CHK);

    // 5: reset during reg 7 frame
    got_q.delete(); rdy_mode = 0; n = 0;
    start_req = 1;
    tick();
    while (got_q.size() < 37 && n < 500) begin tick(); n++; end
    check("reached_reg7", got_q.size(), 37);
    RESET = 1'b0;
    tick();
    check("abort_valid", TX_VALID, 1'b0);
    check("abort_busy", BUSY, 1'b0);
    RESET = 1'b1;
    run_dump(0, n);
    compare_stream("after_abort");
    if (got_q.size() > 0) check("after_abort_hdr", got_q[0], 8'hA0);

    // single-register instance: exactly one frame, no wrap
    regs[30] = 32'hDEAD_BEEF;
    got2_q.delete(); done2_cnt = 0;
    start2_req = 1;
    repeat (20) tick();
    check("one_nbytes", got2_q.size(), 5 + CHK);
    if (got2_q.size() >= 5) begin
      check("one_hdr", got2_q[0], 8'hBE);
      check("one_b1", got2_q[1], 8'hDE);
      check("one_b4", got2_q[4], 8'hEF);
    end
    check("one_done", done2_cnt, 1);
    check("one_addr", addr2, 5'd30);
    check("one_busy", busy2, 1'b0);

`ifdef REG_DUMP_CHECKSUM_EN
    // 6: trailer = XOR of all bytes
    for (int k = 0; k < 32; k++) regs[k] = '0;
    regs[5] = 32'h1234_5678;
    build_exp(0, 31);
    run_dump(0, n);
    compare_stream("chk");
    check("chk_nbytes", got_q.size(), 161);
    if (got_q.size() == 161) check("chk_trailer", got_q[160], 8'h08);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
